vx_issue_watchdog: RTL and testbench

- Synthesizable liveness/protocol monitor for the issue stage; sits beside scoreboard and operand collector and observes their handshakes, never drives them.
- Generalizes per-register clear checks to NUM_WARPS x NUM_REGS with bounded timeouts.
- Tracks up to MAX_PENDING outstanding scoreboard-to-operands transactions with a latency bound, and bounds bank-collision duration.
- First error is captured sticky for CSR/debug readout; subsequent errors are counted.

---
 rtl/vx_issue_watchdog.sv | 254 +++++++++++++++++++++++++
 tb/tb_vx_issue_watchdog.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vx_issue_watchdog.sv
// Issue-stage watchdog: passively observes scoreboard set/clear, operand-bank
// collisions and scoreboard->operands handshakes, and raises bounded-timeout
// and protocol errors with a sticky first-error capture and a saturating count.
module vx_issue_watchdog #(
    parameter int NUM_WARPS         = 4,
    parameter int NUM_REGS          = 32,
    parameter int REG_TIMEOUT       = 1024,
    parameter int COLLISION_TIMEOUT = 4,
    parameter int OPERAND_LATENCY   = 5,
    parameter int MAX_PENDING       = 4,
    localparam int WW = $clog2(NUM_WARPS),
    localparam int RW = $clog2(NUM_REGS),
    localparam int PW = $clog2(MAX_PENDING)
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          enable_i,
    input  logic          set_valid_i,
    input  logic [WW-1:0] set_wid_i,
    input  logic [RW-1:0] set_reg_i,
    input  logic          clr_valid_i,
    input  logic [WW-1:0] clr_wid_i,
    input  logic [RW-1:0] clr_reg_i,
    input  logic          has_collision_i,
    input  logic          sb_fire_i,
    input  logic          opd_fire_i,
    input  logic          err_clr_i,
    output logic          err_valid_o,
    output logic [2:0]    err_code_o,
    output logic [WW-1:0] err_wid_o,
    output logic [RW-1:0] err_reg_o,
    output logic [7:0]    err_count_o,
    output logic [PW:0]   pending_cnt_o
);

    // Flat register index is {wid, reg}; NUM_WARPS and NUM_REGS are powers of two.
    localparam int NE   = NUM_WARPS * NUM_REGS;
    localparam int IW   = WW + RW;
    localparam int AW   = $clog2(REG_TIMEOUT + 1);
    localparam int CW   = $clog2(COLLISION_TIMEOUT + 2);
    localparam int OW   = $clog2(OPERAND_LATENCY + 1);
    localparam int CNTW = PW + 1;

    function automatic logic [7:0] sat8(input logic [15:0] v);
        return (v > 16'd255) ? 8'hFF : v[7:0];
    endfunction

    logic [NE-1:0]   inUse_q, inUse_d, setHitV, clrHitV, toErrV;
    logic [AW-1:0]   age_q [NE];
    logic [AW-1:0]   age_d [NE];
    logic [IW-1:0]   setIdx, clrIdx, toIdx;
    logic            sameReg, dblErr, spurErr;
    logic [CW-1:0]   collCnt_q, collCnt_d;
    logic            collErr;
    logic [OW-1:0]   opAge_q [MAX_PENDING];
    logic [OW-1:0]   opAge_d [MAX_PENDING];
    logic [MAX_PENDING-1:0] rep_q, rep_d;
    logic [PW-1:0]   head_q, head_d, tail;
    logic [CNTW-1:0] count_q, count_d;
    logic            full, empty, doPush, doPop, opdErr, ovfErr, unfErr;
    logic            anyErr;
    logic [2:0]      selCode;
    logic [WW-1:0]   selWid;
    logic [RW-1:0]   selReg;
    logic [15:0]     evCnt;
    logic            errValid_q, errValid_d, pendValid_q, pendValid_d;
    logic [2:0]      errCode_q, errCode_d, pendCode_q, pendCode_d;
    logic [WW-1:0]   errWid_q, errWid_d, pendWid_q, pendWid_d;
    logic [RW-1:0]   errReg_q, errReg_d, pendReg_q, pendReg_d;
    logic [7:0]      errCount_q, errCount_d, pendCnt_q, pendCnt_d;

    assign setIdx  = {set_wid_i, set_reg_i};
    assign clrIdx  = {clr_wid_i, clr_reg_i};
    assign setHitV = set_valid_i ? (NE'(1) << setIdx) : '0;
    assign clrHitV = clr_valid_i ? (NE'(1) << clrIdx) : '0;
    assign sameReg = set_valid_i && clr_valid_i && (setIdx == clrIdx);
    assign dblErr  = enable_i && set_valid_i && inUse_q[setIdx] && !sameReg;
    assign spurErr = enable_i && clr_valid_i && !inUse_q[clrIdx] && !sameReg;

    // In-use bits follow set/clear even when disabled; ages advance only when enabled,
    // and a timeout is flagged on the cycle the age steps onto REG_TIMEOUT.
    always_comb begin
        inUse_d = inUse_q;
        age_d   = age_q;
        toErrV  = '0;
        for (int i = 0; i < NE; i++) begin
            if (clrHitV[i]) inUse_d[i] = 1'b0;
            if (setHitV[i]) begin
                inUse_d[i] = 1'b1;
                age_d[i]   = '0;
            end else if (enable_i && inUse_q[i] && !clrHitV[i] &&
                         age_q[i] != AW'(REG_TIMEOUT)) begin
                age_d[i] = age_q[i] + AW'(1);
                if (age_q[i] == AW'(REG_TIMEOUT - 1)) toErrV[i] = 1'b1;
            end
        end
    end

    // Collision run length, saturating one past the limit so the error fires once per run.
    always_comb begin
        collCnt_d = collCnt_q;
        collErr   = 1'b0;
        if (enable_i) begin
            if (has_collision_i) begin
                if (collCnt_q != CW'(COLLISION_TIMEOUT + 1)) collCnt_d = collCnt_q + CW'(1);
                collErr = (collCnt_q == CW'(COLLISION_TIMEOUT));
            end else begin
                collCnt_d = '0;
            end
        end
    end

    assign full  = (count_q == CNTW'(MAX_PENDING));
    assign empty = (count_q == '0);
    assign tail  = head_q + count_q[PW-1:0];

    // Age FIFO of outstanding scoreboard->operands transactions; a pop frees the head
    // before a push claims a slot, so push+pop on a full FIFO is legal.
    always_comb begin
        opAge_d = opAge_q;
        rep_d   = rep_q;
        head_d  = head_q;
        count_d = count_q;
        doPop   = 1'b0;
        doPush  = 1'b0;
        opdErr  = 1'b0;
        ovfErr  = 1'b0;
        unfErr  = 1'b0;
        if (enable_i) begin
            opdErr = !empty && !rep_q[head_q] && (opAge_q[head_q] == OW'(OPERAND_LATENCY));
            if (opdErr) rep_d[head_q] = 1'b1;
            for (int j = 0; j < MAX_PENDING; j++) begin
                if (opAge_q[j] != OW'(OPERAND_LATENCY)) opAge_d[j] = opAge_q[j] + OW'(1);
            end
            doPop  = opd_fire_i && !empty;
            unfErr = opd_fire_i && empty;
            doPush = sb_fire_i && (!full || doPop);
            ovfErr = sb_fire_i && !doPush;
            if (doPop) head_d = head_q + PW'(1);
            if (doPush) begin
                opAge_d[tail] = '0;
                rep_d[tail]   = 1'b0;
            end
            count_d = count_q + CNTW'(doPush) - CNTW'(doPop);
        end
    end

    // Pick the lowest code raised this cycle (lowest flat index for timeouts) and count all events.
    always_comb begin
        toIdx = '0;
        evCnt = 16'(dblErr) + 16'(spurErr) + 16'(collErr) + 16'(opdErr) + 16'(ovfErr) + 16'(unfErr);
        for (int i = NE - 1; i >= 0; i--) begin
            if (toErrV[i]) toIdx = IW'(i);
            evCnt = evCnt + 16'(toErrV[i]);
        end
        anyErr  = 1'b1;
        selCode = 3'd0;
        selWid  = '0;
        selReg  = '0;
        if (|toErrV) begin
            selCode = 3'd1; selWid = toIdx[IW-1:RW]; selReg = toIdx[RW-1:0];
        end else if (dblErr) begin
            selCode = 3'd2; selWid = set_wid_i; selReg = set_reg_i;
        end else if (spurErr) begin
            selCode = 3'd3; selWid = clr_wid_i; selReg = clr_reg_i;
        end else if (collErr) selCode = 3'd4;
        else if (opdErr)      selCode = 3'd5;
        else if (ovfErr)      selCode = 3'd6;
        else if (unfErr)      selCode = 3'd7;
        else                  anyErr  = 1'b0;
    end

    // Sticky capture; errors arriving on an err_clr edge are parked and landed one cycle later.
    always_comb begin
        errValid_d  = errValid_q;
        errCode_d   = errCode_q;
        errWid_d    = errWid_q;
        errReg_d    = errReg_q;
        errCount_d  = errCount_q;
        pendValid_d = 1'b0;
        pendCode_d  = '0;
        pendWid_d   = '0;
        pendReg_d   = '0;
        pendCnt_d   = '0;
        if (err_clr_i) begin
            errValid_d  = 1'b0;
            errCode_d   = '0;
            errWid_d    = '0;
            errReg_d    = '0;
            errCount_d  = '0;
            pendValid_d = pendValid_q || anyErr;
            pendCode_d  = pendValid_q ? pendCode_q : selCode;
            pendWid_d   = pendValid_q ? pendWid_q  : selWid;
            pendReg_d   = pendValid_q ? pendReg_q  : selReg;
            pendCnt_d   = sat8(16'(pendCnt_q) + evCnt);
        end else begin
            errCount_d = sat8(16'(errCount_q) + 16'(pendCnt_q) + evCnt);
            if (!errValid_q && pendValid_q) begin
                errValid_d = 1'b1; errCode_d = pendCode_q; errWid_d = pendWid_q; errReg_d = pendReg_q;
            end else if (!errValid_q && anyErr) begin
                errValid_d = 1'b1; errCode_d = selCode; errWid_d = selWid; errReg_d = selReg;
            end
        end
    end

    // All monitor state registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            inUse_q     <= '0;
            age_q       <= '{default: '0};
            collCnt_q   <= '0;
            opAge_q     <= '{default: '0};
            rep_q       <= '0;
            head_q      <= '0;
            count_q     <= '0;
            errValid_q  <= 1'b0;
            errCode_q   <= '0;
            errWid_q    <= '0;
            errReg_q    <= '0;
            errCount_q  <= '0;
            pendValid_q <= 1'b0;
            pendCode_q  <= '0;
            pendWid_q   <= '0;
            pendReg_q   <= '0;
            pendCnt_q   <= '0;
        end else begin
            inUse_q     <= inUse_d;
            age_q       <= age_d;
            collCnt_q   <= collCnt_d;
            opAge_q     <= opAge_d;
            rep_q       <= rep_d;
            head_q      <= head_d;
            count_q     <= count_d;
            errValid_q  <= errValid_d;
            errCode_q   <= errCode_d;
            errWid_q    <= errWid_d;
            errReg_q    <= errReg_d;
            errCount_q  <= errCount_d;
            pendValid_q <= pendValid_d;
            pendCode_q  <= pendCode_d;
            pendWid_q   <= pendWid_d;
            pendReg_q   <= pendReg_d;
            pendCnt_q   <= pendCnt_d;
        end
    end

    assign err_valid_o   = errValid_q;
    assign err_code_o    = errCode_q;
    assign err_wid_o     = errWid_q;
    assign err_reg_o     = errReg_q;
    assign err_count_o   = errCount_q;
    assign pending_cnt_o = count_q;

endmodule

// File: tb/tb_vx_issue_watchdog.sv
// Directed bench for vx_issue_watchdog: a per-cycle vector table for the collision
// and operand-FIFO checks, plus hand sequences for register tracking, enable and reset.
module tb_vx_issue_watchdog;

    typedef struct {
        logic       en, sv, cv, coll, sb, opd, eclr;
        logic [1:0] sw, cw;
        logic [4:0] sr, cr;
        logic       expV;
        logic [2:0] expCode;
        logic [7:0] expCnt;
        logic [2:0] expPend;
    } vec_t;

    logic       clk = 1'b0, resetN = 1'b0, enable = 1'b1;
    logic       setValid = 1'b0, clrValid = 1'b0, hasCollision = 1'b0;
    logic       sbFire = 1'b0, opdFire = 1'b0, errClr = 1'b0;
    logic [1:0] setWid = '0, clrWid = '0;
    logic [4:0] setReg = '0, clrReg = '0;
    logic       errValid;
    logic [2:0] errCode;
    logic [1:0] errWid;
    logic [4:0] errReg;
    logic [7:0] errCount;
    logic [2:0] pendingCnt;

    int   nCompared = 0;
    int   nMismatched = 0;
    vec_t tbl [$];

    vx_issue_watchdog #(
        .NUM_WARPS(4), .NUM_REGS(32), .REG_TIMEOUT(8),
        .COLLISION_TIMEOUT(4), .OPERAND_LATENCY(5), .MAX_PENDING(4)
    ) dut (
        .clk_i(clk), .reset_n_i(resetN), .enable_i(enable),
        .set_valid_i(setValid), .set_wid_i(setWid), .set_reg_i(setReg),
        .clr_valid_i(clrValid), .clr_wid_i(clrWid), .clr_reg_i(clrReg),
        .has_collision_i(hasCollision), .sb_fire_i(sbFire), .opd_fire_i(opdFire),
        .err_clr_i(errClr), .err_valid_o(errValid), .err_code_o(errCode),
        .err_wid_o(errWid), .err_reg_o(errReg), .err_count_o(errCount),
        .pending_cnt_o(pendingCnt)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    function automatic vec_t mkStim(input logic en, sv, input logic [1:0] sw, input logic [4:0] sr,
                                    input logic cv, input logic [1:0] cw, input logic [4:0] cr,
                                    input logic coll, eclr);
        vec_t v;
        v = '{default: '0};
        v.en = en; v.sv = sv; v.sw = sw; v.sr = sr;
        v.cv = cv; v.cw = cw; v.cr = cr; v.coll = coll; v.eclr = eclr;
        return v;
    endfunction

    task automatic addRow(input int n, input logic coll, sb, opd, eclr,
                          input logic expV, input logic [2:0] code, input logic [7:0] cnt,
                          input logic [2:0] pend);
        vec_t v;
        v = '{default: '0};
        v.en = 1'b1; v.coll = coll; v.sb = sb; v.opd = opd; v.eclr = eclr;
        v.expV = expV; v.expCode = code; v.expCnt = cnt; v.expPend = pend;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    task automatic cmp(input string tag, input int id, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s #%0d: got %0d, expected %0d", tag, id, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then settle before checking.
    task automatic applyStimulus(input vec_t v);
        enable = v.en; setValid = v.sv; setWid = v.sw; setReg = v.sr;
        clrValid = v.cv; clrWid = v.cw; clrReg = v.cr;
        hasCollision = v.coll; sbFire = v.sb; opdFire = v.opd; errClr = v.eclr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int id, input logic v, input logic [2:0] code,
                               input logic [1:0] wid, input logic [4:0] rg, input logic [7:0] cnt,
                               input logic [2:0] pend);
        cmp({tag, ".err_valid"}, id, errValid, v);
        cmp({tag, ".err_code"}, id, errCode, code);
        cmp({tag, ".err_wid"}, id, errWid, wid);
        cmp({tag, ".err_reg"}, id, errReg, rg);
        cmp({tag, ".err_count"}, id, errCount, cnt);
        cmp({tag, ".pending_cnt"}, id, pendingCnt, pend);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        // collision: 4-high run is fine, 5-high run raises code 4 exactly once
        addRow(4, 1, 0, 0, 0, 0, 0, 0, 0);
        addRow(1, 0, 0, 0, 0, 0, 0, 0, 0);
        addRow(4, 1, 0, 0, 0, 0, 0, 0, 0);
        addRow(3, 1, 0, 0, 0, 1, 4, 1, 0);
        addRow(1, 0, 0, 0, 1, 0, 0, 0, 0);
        // operand latency: pop 5 cycles after push is legal, 6 cycles raises code 5
        addRow(1, 0, 1, 0, 0, 0, 0, 0, 1);
        addRow(4, 0, 0, 0, 0, 0, 0, 0, 1);
        addRow(1, 0, 0, 1, 0, 0, 0, 0, 0);
        addRow(1, 0, 1, 0, 0, 0, 0, 0, 1);
        addRow(5, 0, 0, 0, 0, 0, 0, 0, 1);
        addRow(1, 0, 0, 1, 0, 1, 5, 1, 0);
        addRow(1, 0, 0, 1, 0, 1, 5, 2, 0);
        addRow(1, 0, 0, 0, 1, 0, 0, 0, 0);
        // underflow, and an underflow coincident with err_clr landing one cycle later
        addRow(1, 0, 0, 1, 0, 1, 7, 1, 0);
        addRow(1, 0, 0, 1, 1, 0, 0, 0, 0);
        addRow(1, 0, 0, 0, 0, 1, 7, 1, 0);
        addRow(1, 0, 0, 0, 1, 0, 0, 0, 0);
        // overflow, full push+pop, then head timeouts reported once per entry
        addRow(1, 0, 1, 0, 0, 0, 0, 0, 1);
        addRow(1, 0, 1, 0, 0, 0, 0, 0, 2);
        addRow(1, 0, 1, 0, 0, 0, 0, 0, 3);
        addRow(1, 0, 1, 0, 0, 0, 0, 0, 4);
        addRow(1, 0, 1, 0, 0, 1, 6, 1, 4);
        addRow(1, 0, 1, 1, 0, 1, 6, 1, 4);
        addRow(1, 0, 0, 0, 1, 0, 0, 0, 4);
        addRow(1, 0, 0, 0, 0, 1, 5, 1, 4);
        addRow(1, 0, 0, 1, 0, 1, 5, 1, 3);
        addRow(2, 0, 0, 0, 0, 1, 5, 2, 3);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hold", 0, 0, 0, 0, 0, 0, 0);
        resetN = 1'b1;
        idle(1);
        checkOutput("after_reset", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput("vec", i, tbl[i].expV, tbl[i].expCode, 2'd0, 5'd0, tbl[i].expCnt, tbl[i].expPend);
        end

        // asynchronous reset with errors latched clears outputs without a clock edge
        #2 resetN = 1'b0;
        #1 checkOutput("async_reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 resetN = 1'b1;
        idle(4);
        checkOutput("post_reset_quiet", 0, 0, 0, 0, 0, 0, 0);

        // register timeout on w1/r5 after 8 cycles in use, counted once
        applyStimulus(mkStim(1, 1, 2'd1, 5'd5, 0, 0, 0, 0, 0));
        idle(7);
        checkOutput("reg_age7", 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        checkOutput("reg_timeout", 0, 1, 1, 2'd1, 5'd5, 1, 0);
        idle(3);
        checkOutput("reg_timeout_once", 0, 1, 1, 2'd1, 5'd5, 1, 0);
        applyStimulus(mkStim(1, 0, 0, 0, 1, 2'd1, 5'd5, 0, 1));
        checkOutput("reg_clear", 0, 0, 0, 0, 0, 0, 0);

        // clearing on the last cycle before the limit avoids the timeout
        applyStimulus(mkStim(1, 1, 2'd1, 5'd5, 0, 0, 0, 0, 0));
        idle(7);
        applyStimulus(mkStim(1, 0, 0, 0, 1, 2'd1, 5'd5, 0, 0));
        checkOutput("reg_clear_in_time", 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        checkOutput("reg_quiet", 0, 0, 0, 0, 0, 0, 0);

        // double set then spurious clear
        applyStimulus(mkStim(1, 1, 2'd0, 5'd3, 0, 0, 0, 0, 0));
        applyStimulus(mkStim(1, 1, 2'd0, 5'd3, 0, 0, 0, 0, 0));
        checkOutput("double_set", 0, 1, 2, 2'd0, 5'd3, 1, 0);
        applyStimulus(mkStim(1, 0, 0, 0, 1, 2'd0, 5'd3, 0, 1));
        checkOutput("clr_after_dbl", 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(mkStim(1, 0, 0, 0, 1, 2'd2, 5'd9, 0, 0));
        checkOutput("spurious_clr", 0, 1, 3, 2'd2, 5'd9, 1, 0);
        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 1));

        // same-cycle set+clear on one register leaves it in use without error
        applyStimulus(mkStim(1, 1, 2'd3, 5'd1, 1, 2'd3, 5'd1, 0, 0));
        checkOutput("set_clr_same", 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(mkStim(1, 1, 2'd3, 5'd1, 0, 0, 0, 0, 0));
        checkOutput("set_clr_then_set", 0, 1, 2, 2'd3, 5'd1, 1, 0);
        applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0, 0, 1));

        // disabled: clear still tracked, long collision run raises nothing
        applyStimulus(mkStim(0, 0, 0, 0, 1, 2'd3, 5'd1, 1, 0));
        for (int k = 0; k < 7; k++) applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 1, 0));
        checkOutput("disabled_quiet", 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(mkStim(1, 0, 0, 0, 1, 2'd3, 5'd1, 0, 0));
        checkOutput("clr_tracked_disabled", 0, 1, 3, 2'd3, 5'd1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
